// File: rtl/sdram_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sdram_pkg
// Description : Shared widths, read-data routing tags and arbiter state
//               encoding for the SDRAM write-port sharing logic.
// Revision    : 1.0 - initial release
// ============================================================================
package sdram_pkg;

    localparam int ADDR_W = 26;
    localparam int DATA_W = 32;
    localparam int STRB_W = 4;

    // Width of one buffered blitter entry: {address, wstrb, wdata}
    localparam int ENTRY_W = ADDR_W + STRB_W + DATA_W;

    // mem_source tag values, used downstream to route read data
    localparam logic SRC_BLIT = 1'b0;
    localparam logic SRC_CPU  = 1'b1;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_BLIT = 2'd1,
        ARB_CPU  = 2'd2
    } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo
// Description : Single-clock FIFO with registered occupancy count.
//               A push while full is accepted only if a pop happens in the
//               same cycle; a pop while empty is ignored. Read data is the
//               current head entry (combinational from storage).
// Ports       : clock, reset         - clock / synchronous active-high reset
//               push, wdata          - write strobe and entry
//               pop, rdata           - consume head / head entry
//               count, full, empty   - occupancy status
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
    parameter int WIDTH = 62,
    parameter int DEPTH = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic w_push;
    logic w_pop;

    assign full  = (r_count == CNT_W'(DEPTH));
    assign empty = (r_count == '0);
    assign count = r_count;
    assign rdata = r_mem[r_rd_ptr];

    assign w_pop  = pop && !empty;
    // A simultaneous pop frees the slot being written, so full does not block
    assign w_push = push && (!full || w_pop);

    // Storage carries no reset; contents are qualified by the count
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= wdata;
        end
    end

    // DEPTH is a power of two, so pointers wrap naturally
    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/blit_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : blit_write_arbiter
// Description : Shares the SDRAM arbiter write port between the blitter
//               combined-write stream (buffered in a FIFO, no backpressure)
//               and the CPU data port. Grants are round-robin, except that
//               the blitter wins outright once its FIFO reaches HIGH_WATER.
// Ports       : clock, reset                        - clock / sync reset
//               blit_write/address/wstrb/wdata      - blitter word stream
//               blit_stall, blit_overflow           - FIFO status to blitter
//               cpu_request/write/address/wstrb/wdata, cpu_ack - CPU port
//               mem_request/write/address/wstrb/wdata/source, mem_ack
//                                                   - SDRAM arbiter port
// Revision    : 1.0 - initial release
// ============================================================================
module blit_write_arbiter
    import sdram_pkg::*;
#(
    parameter int FIFO_DEPTH  = 8,
    parameter int ALMOST_FULL = 6,
    parameter int HIGH_WATER  = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              blit_write,
    input  logic [ADDR_W-1:0] blit_address,
    input  logic [STRB_W-1:0] blit_wstrb,
    input  logic [DATA_W-1:0] blit_wdata,
    output logic              blit_stall,
    output logic              blit_overflow,
    input  logic              cpu_request,
    input  logic              cpu_write,
    input  logic [ADDR_W-1:0] cpu_address,
    input  logic [STRB_W-1:0] cpu_wstrb,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic              mem_request,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_address,
    output logic [STRB_W-1:0] mem_wstrb,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_source,
    input  logic              mem_ack
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    arb_state_t        r_state;
    logic              r_last_grant;
    logic              r_mem_request;
    logic              r_mem_write;
    logic [ADDR_W-1:0] r_mem_address;
    logic [STRB_W-1:0] r_mem_wstrb;
    logic [DATA_W-1:0] r_mem_wdata;
    logic              r_mem_source;
    logic              r_cpu_ack;
    logic              r_blit_stall;
    logic              r_blit_overflow;

    logic [ADDR_W-1:0]  w_blit_address;
    logic [ENTRY_W-1:0] w_fifo_head;
    logic [CNT_W-1:0]   w_count;
    logic               w_full;
    logic               w_empty;
    logic               w_blit_pick;
    logic               w_pop;
    logic               w_drop;

    // Blitter addresses are word aligned; the low bits are cleared on entry
    assign w_blit_address = blit_address & ~ADDR_W'(3);

    // Blitter wins when the CPU is absent, the FIFO is backing up, or the
    // CPU had the previous grant
    assign w_blit_pick = !w_empty &&
                         (!cpu_request ||
                          (w_count >= CNT_W'(HIGH_WATER)) ||
                          (r_last_grant == SRC_CPU));

    // The only pop point is the IDLE -> BLIT transition
    assign w_pop  = (r_state == ARB_IDLE) && w_blit_pick;
    assign w_drop = blit_write && w_full && !w_pop;

    sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (blit_write),
        .wdata ({w_blit_address, blit_wstrb, blit_wdata}),
        .pop   (w_pop),
        .rdata (w_fifo_head),
        .count (w_count),
        .full  (w_full),
        .empty (w_empty)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state         <= ARB_IDLE;
            r_last_grant    <= SRC_CPU;
            r_mem_request   <= 1'b0;
            r_mem_write     <= 1'b0;
            r_mem_address   <= '0;
            r_mem_wstrb     <= '0;
            r_mem_wdata     <= '0;
            r_mem_source    <= SRC_BLIT;
            r_cpu_ack       <= 1'b0;
            r_blit_stall    <= 1'b0;
            r_blit_overflow <= 1'b0;
        end else begin
            r_cpu_ack    <= 1'b0;
            // Built from the registered count, hence one cycle behind it
            r_blit_stall <= (w_count >= CNT_W'(ALMOST_FULL));
            if (w_drop) begin
                r_blit_overflow <= 1'b1;
            end

            case (r_state)
                ARB_IDLE: begin
                    if (w_blit_pick) begin
                        r_state       <= ARB_BLIT;
                        r_mem_request <= 1'b1;
                        r_mem_write   <= 1'b1;
                        r_mem_source  <= SRC_BLIT;
                        {r_mem_address, r_mem_wstrb, r_mem_wdata} <= w_fifo_head;
                    end else if (cpu_request) begin
                        r_state       <= ARB_CPU;
                        r_mem_request <= 1'b1;
                        r_mem_write   <= cpu_write;
                        r_mem_source  <= SRC_CPU;
                        r_mem_address <= cpu_address;
                        r_mem_wstrb   <= cpu_wstrb;
                        r_mem_wdata   <= cpu_wdata;
                    end
                end
                ARB_BLIT, ARB_CPU: begin
                    // Request fields stay frozen until the arbiter accepts
                    if (mem_ack) begin
                        r_state       <= ARB_IDLE;
                        r_mem_request <= 1'b0;
                        r_last_grant  <= r_mem_source;
                        r_cpu_ack     <= (r_state == ARB_CPU);
                    end
                end
                default: begin
                    r_state       <= ARB_IDLE;
                    r_mem_request <= 1'b0;
                end
            endcase
        end
    end

    assign mem_request   = r_mem_request;
    assign mem_write     = r_mem_write;
    assign mem_address   = r_mem_address;
    assign mem_wstrb     = r_mem_wstrb;
    assign mem_wdata     = r_mem_wdata;
    assign mem_source    = r_mem_source;
    assign cpu_ack       = r_cpu_ack;
    assign blit_stall    = r_blit_stall;
    assign blit_overflow = r_blit_overflow;

endmodule
`default_nettype wire

// File: tb/tb_blit_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_blit_write_arbiter
// Description : Directed testbench for blit_write_arbiter. Expected SDRAM
//               transactions are queued in grant order by the stimulus; a
//               monitor pops and compares them on every accepted request and
//               also checks request stability and cpu_ack timing.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_blit_write_arbiter;
    import sdram_pkg::*;

    typedef struct packed {
        logic              src;
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [STRB_W-1:0] strb;
        logic [DATA_W-1:0] data;
    } txn_t;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              blit_write = 1'b0;
    logic [ADDR_W-1:0] blit_address = '0;
    logic [STRB_W-1:0] blit_wstrb = '0;
    logic [DATA_W-1:0] blit_wdata = '0;
    logic              blit_stall;
    logic              blit_overflow;
    logic              cpu_request = 1'b0;
    logic              cpu_write = 1'b0;
    logic [ADDR_W-1:0] cpu_address = '0;
    logic [STRB_W-1:0] cpu_wstrb = '0;
    logic [DATA_W-1:0] cpu_wdata = '0;
    logic              cpu_ack;
    logic              mem_request;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_address;
    logic [STRB_W-1:0] mem_wstrb;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_source;
    logic              mem_ack = 1'b0;

    int   n_checks = 0;
    int   n_fail   = 0;
    txn_t exp_q[$];

    bit   ack_en    = 1'b1;
    int   ack_delay = 0;
    int   ack_wait  = 0;

    txn_t mon_cur;
    txn_t mon_prev;
    txn_t mon_exp;
    bit   mon_have_prev = 1'b0;
    logic mon_exp_ack   = 1'b0;

    always #5 clock = ~clock;

    blit_write_arbiter #(
        .FIFO_DEPTH  (8),
        .ALMOST_FULL (6),
        .HIGH_WATER  (4)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .blit_write    (blit_write),
        .blit_address  (blit_address),
        .blit_wstrb    (blit_wstrb),
        .blit_wdata    (blit_wdata),
        .blit_stall    (blit_stall),
        .blit_overflow (blit_overflow),
        .cpu_request   (cpu_request),
        .cpu_write     (cpu_write),
        .cpu_address   (cpu_address),
        .cpu_wstrb     (cpu_wstrb),
        .cpu_wdata     (cpu_wdata),
        .cpu_ack       (cpu_ack),
        .mem_request   (mem_request),
        .mem_write     (mem_write),
        .mem_address   (mem_address),
        .mem_wstrb     (mem_wstrb),
        .mem_wdata     (mem_wdata),
        .mem_source    (mem_source),
        .mem_ack       (mem_ack)
    );

    function automatic void check(input string name, input logic [63:0] act,
                                  input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endfunction

    function automatic void expect_txn(input logic src, input logic wr,
                                       input logic [ADDR_W-1:0] a,
                                       input logic [STRB_W-1:0] s,
                                       input logic [DATA_W-1:0] d);
        txn_t t;
        t = {src, wr, a, s, d};
        exp_q.push_back(t);
    endfunction

    // SDRAM arbiter model: acknowledges after ack_delay waiting cycles
    always @(posedge clock) begin
        #1;
        if (mem_request && ack_en && !reset) begin
            if (ack_wait >= ack_delay) begin
                mem_ack  = 1'b1;
                ack_wait = 0;
            end else begin
                mem_ack  = 1'b0;
                ack_wait = ack_wait + 1;
            end
        end else begin
            mem_ack  = 1'b0;
            ack_wait = 0;
        end
    end

    // Monitor: scoreboard pop on acceptance, stability and cpu_ack timing
    always @(negedge clock) begin
        if (reset) begin
            mon_have_prev = 1'b0;
            mon_exp_ack   = 1'b0;
        end else begin
            check("cpu_ack", {63'd0, cpu_ack}, {63'd0, mon_exp_ack});
            mon_exp_ack = 1'b0;
            if (mem_request) begin
                mon_cur = {mem_source, mem_write, mem_address, mem_wstrb, mem_wdata};
                if (mon_have_prev) begin
                    check("mem_stable", mon_cur, mon_prev);
                end
                if (mem_ack) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL mem_txn: got %0h, expected no transaction", mon_cur);
                    end else begin
                        mon_exp = exp_q.pop_front();
                        check("mem_txn", mon_cur, mon_exp);
                    end
                    mon_exp_ack   = mem_source;
                    mon_have_prev = 1'b0;
                end else begin
                    mon_prev      = mon_cur;
                    mon_have_prev = 1'b1;
                end
            end else begin
                mon_have_prev = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic blit_push(input logic [ADDR_W-1:0] a, input logic [STRB_W-1:0] s,
                             input logic [DATA_W-1:0] d);
        blit_write   = 1'b1;
        blit_address = a;
        blit_wstrb   = s;
        blit_wdata   = d;
        tick();
        blit_write   = 1'b0;
    endtask

    task automatic cpu_txn(input logic w, input logic [ADDR_W-1:0] a,
                           input logic [STRB_W-1:0] s, input logic [DATA_W-1:0] d);
        int k;
        cpu_request = 1'b1;
        cpu_write   = w;
        cpu_address = a;
        cpu_wstrb   = s;
        cpu_wdata   = d;
        for (k = 0; k < 400; k++) begin
            tick();
            if (cpu_ack) break;
        end
        n_checks++;
        if (k == 400) begin
            n_fail++;
            $display("FAIL cpu_ack_timeout: got no cpu_ack, expected one within 400 cycles");
        end
        cpu_request = 1'b0;
    endtask

    task automatic wait_drain();
        int k;
        for (k = 0; k < 500; k++) begin
            if (exp_q.size() == 0 && !mem_request) break;
            tick();
        end
        check("drain_pending", 64'(exp_q.size()), 64'd0);
        tick();
    endtask

    initial begin
        int n;
        repeat (3) tick();
        check("rst_mem_request", {63'd0, mem_request}, 64'd0);
        check("rst_cpu_ack", {63'd0, cpu_ack}, 64'd0);
        check("rst_blit_stall", {63'd0, blit_stall}, 64'd0);
        check("rst_blit_overflow", {63'd0, blit_overflow}, 64'd0);
        reset = 1'b0;
        tick();

        // Single blit write, immediate ack, two-edge latency
        expect_txn(SRC_BLIT, 1'b1, 26'h0001004, 4'hF, 32'hDEADBEEF);
        blit_push(26'h0001004, 4'hF, 32'hDEADBEEF);
        check("t1_req_edge1", {63'd0, mem_request}, 64'd0);
        tick();
        check("t1_req_edge2", {63'd0, mem_request}, 64'd1);
        check("t1_source", {63'd0, mem_source}, 64'd0);
        wait_drain();
        check("t1_stall", {63'd0, blit_stall}, 64'd0);

        // CPU read alone, ack delayed by 5 cycles
        ack_delay = 5;
        expect_txn(SRC_CPU, 1'b0, 26'h0000100, 4'h0, 32'h0);
        fork
            cpu_txn(1'b0, 26'h0000100, 4'h0, 32'h0);
            begin
                for (int k = 0; k < 20; k++) begin
                    tick();
                    if (mem_request) break;
                end
                n = 0;
                while (mem_request && n < 50) begin
                    n++;
                    tick();
                end
                check("t2_req_cycles", 64'(n), 64'd6);
            end
        join
        wait_drain();
        ack_delay = 0;

        // Alternation: BLIT, CPU, BLIT, CPU (blit low address bits cleared)
        expect_txn(SRC_BLIT, 1'b1, 26'h0002000, 4'h3, 32'h11111111);
        expect_txn(SRC_CPU,  1'b1, 26'h0003000, 4'hF, 32'h22222222);
        expect_txn(SRC_BLIT, 1'b1, 26'h0002004, 4'hC, 32'h33333333);
        expect_txn(SRC_CPU,  1'b0, 26'h0003004, 4'h0, 32'h0);
        fork
            begin
                blit_push(26'h0002003, 4'h3, 32'h11111111);
                blit_push(26'h0002004, 4'hC, 32'h33333333);
            end
            begin
                tick();
                cpu_txn(1'b1, 26'h0003000, 4'hF, 32'h22222222);
                cpu_txn(1'b0, 26'h0003004, 4'h0, 32'h0);
            end
        join
        wait_drain();

        // High-water priority: blitter wins until count drops below 4
        ack_en = 1'b0;
        expect_txn(SRC_CPU,  1'b1, 26'h0008000, 4'hF, 32'hC0C0C0C0);
        expect_txn(SRC_BLIT, 1'b1, 26'h0009000, 4'hF, 32'hE1E1E1E1);
        expect_txn(SRC_BLIT, 1'b1, 26'h0009004, 4'hF, 32'hE2E2E2E2);
        expect_txn(SRC_CPU,  1'b1, 26'h0008004, 4'hF, 32'hC1C1C1C1);
        expect_txn(SRC_BLIT, 1'b1, 26'h0009008, 4'hF, 32'hE3E3E3E3);
        expect_txn(SRC_CPU,  1'b1, 26'h0008008, 4'hF, 32'hC2C2C2C2);
        expect_txn(SRC_BLIT, 1'b1, 26'h000900C, 4'hF, 32'hE4E4E4E4);
        expect_txn(SRC_CPU,  1'b1, 26'h000800C, 4'hF, 32'hC3C3C3C3);
        expect_txn(SRC_BLIT, 1'b1, 26'h0009010, 4'hF, 32'hE5E5E5E5);
        fork
            begin
                cpu_txn(1'b1, 26'h0008000, 4'hF, 32'hC0C0C0C0);
                cpu_txn(1'b1, 26'h0008004, 4'hF, 32'hC1C1C1C1);
                cpu_txn(1'b1, 26'h0008008, 4'hF, 32'hC2C2C2C2);
                cpu_txn(1'b1, 26'h000800C, 4'hF, 32'hC3C3C3C3);
            end
            begin
                for (int i = 1; i <= 5; i++) begin
                    blit_push(26'h0009000 + 26'((i - 1) * 4), 4'hF, {4{8'hE0 | 8'(i)}});
                end
                ack_en = 1'b1;
            end
        join
        wait_drain();

        // Overflow: CPU stalls the port while 9 words arrive
        ack_en = 1'b0;
        expect_txn(SRC_CPU, 1'b1, 26'h0004000, 4'hF, 32'h44444444);
        for (int i = 1; i <= 8; i++) begin
            expect_txn(SRC_BLIT, 1'b1, 26'h0005000 + 26'((i - 1) * 4), 4'hF,
                       32'hB0000000 + 32'(i));
        end
        fork
            cpu_txn(1'b1, 26'h0004000, 4'hF, 32'h44444444);
            begin
                tick();
                for (int i = 1; i <= 9; i++) begin
                    blit_push(26'h0005000 + 26'((i - 1) * 4), 4'hF, 32'hB0000000 + 32'(i));
                    check($sformatf("t5_stall_push%0d", i), {63'd0, blit_stall},
                          {63'd0, (i >= 7)});
                    check($sformatf("t5_ovf_push%0d", i), {63'd0, blit_overflow},
                          {63'd0, (i == 9)});
                end
                ack_en = 1'b1;
            end
        join
        wait_drain();
        check("t5_stall_after", {63'd0, blit_stall}, 64'd0);
        check("t5_ovf_sticky", {63'd0, blit_overflow}, 64'd1);

        // Reset while a CPU grant waits on mem_ack
        ack_en      = 1'b0;
        cpu_request = 1'b1;
        cpu_write   = 1'b1;
        cpu_address = 26'h0006000;
        cpu_wstrb   = 4'hF;
        cpu_wdata   = 32'h66666666;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (mem_request) break;
        end
        check("t6_req_before", {63'd0, mem_request}, 64'd1);
        check("t6_src_before", {63'd0, mem_source}, 64'd1);
        tick();
        reset = 1'b1;
        tick();
        check("t6_req_reset", {63'd0, mem_request}, 64'd0);
        check("t6_ack_reset", {63'd0, cpu_ack}, 64'd0);
        cpu_request = 1'b0;
        tick();
        reset  = 1'b0;
        ack_en = 1'b1;
        tick();
        check("t6_ovf_cleared", {63'd0, blit_overflow}, 64'd0);
        check("t6_ack_after", {63'd0, cpu_ack}, 64'd0);
        expect_txn(SRC_BLIT, 1'b1, 26'h0007008, 4'h5, 32'h55AA55AA);
        blit_push(26'h0007008, 4'h5, 32'h55AA55AA);
        wait_drain();
        repeat (3) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got no end of test, expected completion within 300000 time units");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/blit_write_arbiter.md
Name: blit_write_arbiter

Overview:
Shares the single SDRAM arbiter write port between the blitter's combined-write stream and the CPU data port. The blitter stream has no backpressure, so its words are buffered in a small FIFO and an almost-full flag is returned to stall the blitter pipeline. A registered request/ack sequencer grants the port round-robin, and switches to blitter priority when the FIFO passes a high-water mark.

Parameters:
FIFO_DEPTH, 8, blitter write FIFO entries; power of two, at least 4
ALMOST_FULL, 6, occupancy at or above which blit_stall asserts
HIGH_WATER, 4, occupancy at or above which the blitter wins arbitration unconditionally

Ports:
clock  in  1  system clock; all logic on rising edge
reset  in  1  synchronous, active-high reset
blit_write  in  1  one-cycle pulse: combined blitter word valid
blit_address  in  26  word-aligned byte address; bits [1:0] ignored and forced to 0
blit_wstrb  in  4  byte enables
blit_wdata  in  32  write data
blit_stall  out  1  registered; 1 when FIFO occupancy >= ALMOST_FULL
blit_overflow  out  1  sticky; set when a blit_write is dropped; cleared only by reset
cpu_request  in  1  held high until cpu_ack
cpu_write  in  1  1 = write, 0 = read; passed through unchanged
cpu_address  in  26  byte address
cpu_wstrb  in  4  byte enables
cpu_wdata  in  32  write data
cpu_ack  out  1  one-cycle pulse when mem_ack completes a CPU grant
mem_request  out  1  registered request to SDRAM arbiter
mem_write  out  1  registered
mem_address  out  26  registered
mem_wstrb  out  4  registered
mem_wdata  out  32  registered
mem_source  out  1  0 = blitter, 1 = CPU; read-data routing tag
mem_ack  in  1  SDRAM arbiter accepted the current request

Behaviour:
- Reset values: mem_request=0, cpu_ack=0, blit_stall=0, blit_overflow=0, FIFO empty, state IDLE, last_grant=CPU (so the blitter wins the first tie). The mem_* data outputs are don't-care while mem_request=0.
- FIFO push: on blit_write when not full. If full and no pop occurs in the same cycle, drop the word and set blit_overflow. If full and a pop occurs in the same cycle, the push succeeds. Count width is clog2(FIFO_DEPTH)+1. Pointers wrap modulo FIFO_DEPTH.
- blit_stall is computed from the registered count, so it appears one cycle after the push that crosses ALMOST_FULL.
- FSM states: IDLE, BLIT, CPU.
- IDLE → BLIT when the FIFO is non-empty and one of these holds: cpu_request=0, count >= HIGH_WATER, or last_grant=CPU. On entry, pop the FIFO head into the mem_* registers and set mem_request=1, mem_write=1, mem_source=0.
- IDLE → CPU otherwise, when cpu_request=1. On entry, latch the cpu_* fields, set mem_request=1 and mem_source=1.
- BLIT/CPU: hold mem_* stable until mem_ack. On the mem_ack cycle, set mem_request=0 next cycle, update last_grant, and return to IDLE.
- In CPU state, cpu_ack pulses in the cycle after mem_ack.
- Minimum latency: a blit_write into an empty FIFO with the FSM in IDLE gives FIFO non-empty at edge N+1 and mem_request=1 at edge N+2. Back-to-back grants therefore have a single IDLE cycle between them.
- A blitter pop occurs only on the IDLE→BLIT transition; at most one pop per cycle.
- If cpu_request drops before being granted, no CPU transaction is issued. If it drops while in CPU state, that is a protocol violation; the transaction still completes.
- Reset mid-transaction: mem_request drops the next cycle, FIFO contents are discarded, and no cpu_ack is issued.
- Simultaneous push and pop on an empty FIFO cannot occur, because a pop requires non-empty registered state.

Decomposition:
- Shared package sdram_pkg: ADDR_W=26, DATA_W=32, STRB_W=4, the mem_source encoding (SRC_BLIT=0, SRC_CPU=1), and the arbiter state enum.
- One sub-module, sync_fifo (parameterised width/depth, push/pop/count/full/empty), holding the 62-bit {address, wstrb, wdata} entry. The FSM stays in blit_write_arbiter.

Test Plan:
- Single blit write (addr 0x0001004, wstrb 0xF, data 0xDEADBEEF), cpu idle, mem_ack in the cycle after the request → mem_request high 2 cycles after the push with exact fields and mem_source=0. Then mem_request low and the FIFO empty.
- CPU request alone (read, addr 0x0000100), mem_ack delayed 5 cycles → mem_* held stable for 5 cycles. Then cpu_ack pulses once, with mem_write=0 and mem_source=1.
- CPU and blitter continuously requesting, count < HIGH_WATER, mem_ack immediate → grants alternate BLIT, CPU, BLIT, CPU.
- 5 blit writes queued with cpu_request held → blitter granted on every grant until the count falls below 4. Then alternation resumes.
- mem_ack held 0 while 9 blit writes are pushed → blit_stall asserts after the 6th push. The 9th push is dropped, blit_overflow=1, and the delivered data equals the first 8 entries in order.
- Reset asserted while in CPU state waiting on mem_ack → next cycle mem_request=0 and cpu_ack never pulses. After release, a new blit write is delivered normally.
